// File: rtl/condicionador_botoes_pkg.sv
// Shared types for the button conditioner: FSM state encoding, default width
// and the one-hot test used to validate a stable press.
package botoes_pkg;

    localparam int N_BOTOES_PADRAO = 4;

    typedef enum logic [2:0] {
        OCIOSO       = 3'd0,
        FILTRA_PRESS = 3'd1,
        PRESSIONADO  = 3'd2,
        FILTRA_SOLTA = 3'd3,
        REJEITADO    = 3'd4
    } estado_t;

    // Callers zero-extend their vector to 32 bits; at most 32 buttons supported.
    function automatic logic eh_one_hot(input logic [31:0] v);
        return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/condicionador_botoes_sincroniza_filtra.sv
// Input synchroniser plus stability counter; flags when the synchronised
// sample has held the same value for CICLOS_ESTAVEL cycles.
module sincroniza_filtra
    import botoes_pkg::*;
#(
    parameter int N_BOTOES       = N_BOTOES_PADRAO,
    parameter int CICLOS_ESTAVEL = 50000,
    parameter int SYNC_ESTAGIOS  = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic [N_BOTOES-1:0] i_botoes_brutos,
    output logic [N_BOTOES-1:0] o_amostra,
    output logic                o_estavel
);

    localparam int CW = $clog2(CICLOS_ESTAVEL);
    localparam logic [CW-1:0] CONT_MAX = CW'(CICLOS_ESTAVEL - 1);

    logic [SYNC_ESTAGIOS-1:0][N_BOTOES-1:0] r_sync;
    logic [CW-1:0]                          r_cont;

    // The counter compares the value about to enter the last stage with the
    // current one, so r_cont always describes the amostra being presented:
    // estavel can never be asserted alongside a freshly changed sample.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            r_sync <= '0;
            r_cont <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_ESTAGIOS-2:0], i_botoes_brutos};
            if (r_sync[SYNC_ESTAGIOS-2] != r_sync[SYNC_ESTAGIOS-1])
                r_cont <= '0;
            else if (r_cont != CONT_MAX)
                r_cont <= r_cont + CW'(1);
        end
    end

    assign o_amostra = r_sync[SYNC_ESTAGIOS-1];
    assign o_estavel = (r_cont == CONT_MAX);

endmodule

// File: rtl/condicionador_botoes.sv
// Button conditioner: sync/debounce, one-hot validation and move strobe.
// Optional BOTOES_CONTADOR_EN adds an 8-bit accepted-move counter output.
module condicionador_botoes
    import botoes_pkg::*;
#(
    parameter int N_BOTOES       = N_BOTOES_PADRAO,
    parameter int CICLOS_ESTAVEL = 50000,
    parameter int SYNC_ESTAGIOS  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_brutos,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] botoes,
    output logic                jogada_feita,
    output logic                ocupado,
    output logic                erro_multiplo,
    output logic [2:0]          db_estado
`ifdef BOTOES_CONTADOR_EN
    ,
    output logic [7:0]          db_num_jogadas
`endif
);

    logic [N_BOTOES-1:0] w_amostra;
    logic                w_estavel;

    sincroniza_filtra #(
        .N_BOTOES      (N_BOTOES),
        .CICLOS_ESTAVEL(CICLOS_ESTAVEL),
        .SYNC_ESTAGIOS (SYNC_ESTAGIOS)
    ) u_sincroniza_filtra (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_botoes_brutos(botoes_brutos),
        .o_amostra      (w_amostra),
        .o_estavel      (w_estavel)
    );

    estado_t             r_estado, w_prox;
    logic [N_BOTOES-1:0] r_botoes, r_codigo;
    logic                r_jogada, r_erro;
    logic                w_captura, w_aceita, w_rejeita;

    always_ff @(posedge clock) begin
        if (!reset) r_estado <= OCIOSO;
        else        r_estado <= w_prox;
    end

    always_comb begin
        w_prox    = r_estado;
        w_captura = 1'b0;
        w_aceita  = 1'b0;
        w_rejeita = 1'b0;
        case (r_estado)
            OCIOSO:
                if (w_amostra != '0) w_prox = FILTRA_PRESS;
            FILTRA_PRESS:
                if (w_amostra == '0) begin
                    w_prox = OCIOSO;
                end else if (w_estavel) begin
                    if (eh_one_hot(32'(w_amostra))) begin
                        w_prox    = PRESSIONADO;
                        w_captura = 1'b1;
                        w_aceita  = habilita;
                    end else begin
                        w_prox    = REJEITADO;
                        w_rejeita = 1'b1;
                    end
                end
            PRESSIONADO:
                if (w_amostra != r_codigo) w_prox = FILTRA_SOLTA;
            REJEITADO:
                if (w_amostra == '0) w_prox = FILTRA_SOLTA;
            FILTRA_SOLTA:
                if (w_estavel && (w_amostra == '0)) w_prox = OCIOSO;
            default:
                w_prox = OCIOSO;
        endcase
    end

    // r_codigo tracks the held code even when habilita=0 leaves botoes stale,
    // so release/slide detection does not depend on whether the move counted.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_botoes <= '0;
            r_codigo <= '0;
            r_jogada <= 1'b0;
            r_erro   <= 1'b0;
        end else begin
            r_jogada <= w_aceita;
            if (w_captura) r_codigo <= w_amostra;
            if (w_aceita) begin
                r_botoes <= w_amostra;
                r_erro   <= 1'b0;
            end else if (w_rejeita) begin
                r_erro   <= 1'b1;
            end
        end
    end

`ifdef BOTOES_CONTADOR_EN
    logic [7:0] r_num_jogadas;

    always_ff @(posedge clock) begin
        if (!reset)        r_num_jogadas <= '0;
        else if (w_aceita) r_num_jogadas <= r_num_jogadas + 8'd1;
    end

    assign db_num_jogadas = r_num_jogadas;
`endif

    assign botoes        = r_botoes;
    assign jogada_feita  = r_jogada;
    assign erro_multiplo = r_erro;
    assign ocupado       = (r_estado != OCIOSO);
    assign db_estado     = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Randomised and directed bench for condicionador_botoes (CICLOS_ESTAVEL=8).
// Expected behaviour comes from a press-episode model, not from FSM internals.
module tb_condicionador_botoes;

    localparam int C = 8;
    localparam int S = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] botoes_brutos;
    logic       habilita;
    logic [3:0] botoes;
    logic       jogada_feita, ocupado, erro_multiplo;
    logic [2:0] db_estado;
`ifdef BOTOES_CONTADOR_EN
    logic [7:0] db_num_jogadas;
`endif

    condicionador_botoes #(.N_BOTOES(4), .CICLOS_ESTAVEL(C), .SYNC_ESTAGIOS(S)) dut (
        .clock        (clock),
        .reset        (reset),
        .botoes_brutos(botoes_brutos),
        .habilita     (habilita),
        .botoes       (botoes),
        .jogada_feita (jogada_feita),
        .ocupado      (ocupado),
        .erro_multiplo(erro_multiplo),
        .db_estado    (db_estado)
`ifdef BOTOES_CONTADOR_EN
        ,
        .db_num_jogadas(db_num_jogadas)
`endif
    );

    always #5 clock = ~clock;

    int n_checks = 0, n_erros = 0;
    int ncyc = 0, n_strobe = 0, t_strobe = 0;
    logic [3:0] m_botoes;
    logic       m_erro;

    // One clock with raw input v; strobe activity is logged after the edge.
    task automatic ciclo(input logic [3:0] v);
        botoes_brutos = v;
        @(posedge clock);
        ncyc++;
        #1;
        if (jogada_feita === 1'b1) begin
            n_strobe++;
            t_strobe = ncyc;
        end
    endtask

    // Bounce pairs (code, 0) shorter than the filter, then a clean hold.
    task automatic pressiona(input logic [3:0] code, input int npares, input int hold, output int t_hold);
        for (int p = 0; p < npares; p++) begin
            repeat ($urandom_range(1, 5)) ciclo(code);
            repeat ($urandom_range(1, 5)) ciclo(4'b0000);
        end
        t_hold = ncyc + 1;
        repeat (hold) ciclo(code);
    endtask

    task automatic solta(input logic [3:0] code, input int npares, input int idle);
        for (int p = 0; p < npares; p++) begin
            repeat ($urandom_range(1, 5)) ciclo(4'b0000);
            repeat ($urandom_range(1, 5)) ciclo(code);
        end
        repeat (idle) ciclo(4'b0000);
    endtask

    task automatic test_reset;
        int th;
        reset = 1'b0; habilita = 1'b1;
        repeat (3) ciclo(4'b0010);
        n_checks++; if (botoes !== 4'b0000) begin n_erros++; $display("FAIL reset_botoes: got %b want 0000", botoes); end
        n_checks++; if (jogada_feita !== 1'b0) begin n_erros++; $display("FAIL reset_strobe: got %b want 0", jogada_feita); end
        n_checks++; if (db_estado !== 3'd0) begin n_erros++; $display("FAIL reset_estado: got %0d want 0", db_estado); end
        n_checks++; if (ocupado !== 1'b0 || erro_multiplo !== 1'b0) begin n_erros++; $display("FAIL reset_flags: got ocupado=%b erro=%b want 0 0", ocupado, erro_multiplo); end
        m_botoes = 4'b0000; m_erro = 1'b0;
        reset = 1'b1; n_strobe = 0;
        pressiona(4'b0010, 0, 14, th);
        m_botoes = 4'b0010;
        n_checks++; if (n_strobe !== 1) begin n_erros++; $display("FAIL reset_press_strobes: got %0d want 1", n_strobe); end
        n_checks++; if (t_strobe - th < S + C - 1 || t_strobe - th > S + C + 1) begin n_erros++; $display("FAIL reset_press_latency: got %0d want %0d+-1", t_strobe - th, S + C); end
        n_checks++; if (botoes !== 4'b0010) begin n_erros++; $display("FAIL reset_press_botoes: got %b want 0010", botoes); end
        solta(4'b0010, 0, 14);
    endtask

    task automatic test_bounce;
        int th;
        n_strobe = 0;
        for (int s = 0; s < 10; s++) repeat (3) ciclo((s % 2 == 0) ? 4'b0001 : 4'b0000);
        n_checks++; if (n_strobe !== 0) begin n_erros++; $display("FAIL bounce_quiet: got %0d strobes want 0", n_strobe); end
        th = ncyc + 1;
        repeat (14) ciclo(4'b0001);
        m_botoes = 4'b0001; m_erro = 1'b0;
        n_checks++; if (n_strobe !== 1) begin n_erros++; $display("FAIL bounce_strobes: got %0d want 1", n_strobe); end
        n_checks++; if (t_strobe - th < S + C - 1 || t_strobe - th > S + C + 1) begin n_erros++; $display("FAIL bounce_latency: got %0d want %0d+-1", t_strobe - th, S + C); end
        n_checks++; if (botoes !== 4'b0001) begin n_erros++; $display("FAIL bounce_botoes: got %b want 0001", botoes); end
        solta(4'b0001, 2, 14);
    endtask

    task automatic test_multiplo;
        int th;
        n_strobe = 0;
        pressiona(4'b0101, 0, 16, th);
        m_erro = 1'b1;
        n_checks++; if (erro_multiplo !== 1'b1) begin n_erros++; $display("FAIL multi_erro: got %b want 1", erro_multiplo); end
        n_checks++; if (n_strobe !== 0) begin n_erros++; $display("FAIL multi_strobe: got %0d want 0", n_strobe); end
        n_checks++; if (db_estado !== 3'd4) begin n_erros++; $display("FAIL multi_estado: got %0d want 4", db_estado); end
        solta(4'b0101, 0, 16);
        n_checks++; if (ocupado !== 1'b0 || erro_multiplo !== 1'b1) begin n_erros++; $display("FAIL multi_release: got ocupado=%b erro=%b want 0 1", ocupado, erro_multiplo); end
        pressiona(4'b1000, 1, 14, th);
        m_botoes = 4'b1000; m_erro = 1'b0;
        n_checks++; if (n_strobe !== 1 || botoes !== 4'b1000) begin n_erros++; $display("FAIL multi_next: got strobes=%0d botoes=%b want 1 1000", n_strobe, botoes); end
        n_checks++; if (erro_multiplo !== 1'b0) begin n_erros++; $display("FAIL multi_clear: got %b want 0", erro_multiplo); end
        solta(4'b1000, 0, 14);
    endtask

    task automatic test_habilita;
        int th;
        n_strobe = 0; habilita = 1'b0;
        pressiona(4'b0100, 0, 14, th);
        n_checks++; if (n_strobe !== 0 || botoes !== m_botoes) begin n_erros++; $display("FAIL hab_off: got strobes=%0d botoes=%b want 0 %b", n_strobe, botoes, m_botoes); end
        n_checks++; if (ocupado !== 1'b1) begin n_erros++; $display("FAIL hab_ocupado: got %b want 1", ocupado); end
        habilita = 1'b1;
        repeat (12) ciclo(4'b0100);
        n_checks++; if (n_strobe !== 0) begin n_erros++; $display("FAIL hab_rise: got %0d strobes want 0", n_strobe); end
        solta(4'b0100, 0, 14);
        n_checks++; if (ocupado !== 1'b0 || botoes !== m_botoes) begin n_erros++; $display("FAIL hab_release: got ocupado=%b botoes=%b want 0 %b", ocupado, botoes, m_botoes); end
    endtask

    task automatic test_slide;
        int th;
        n_strobe = 0;
        pressiona(4'b0001, 0, 14, th);
        m_botoes = 4'b0001; m_erro = 1'b0;
        repeat (20) ciclo(4'b0010);
        n_checks++; if (n_strobe !== 1 || botoes !== 4'b0001) begin n_erros++; $display("FAIL slide_single: got strobes=%0d botoes=%b want 1 0001", n_strobe, botoes); end
        n_checks++; if (db_estado !== 3'd3) begin n_erros++; $display("FAIL slide_estado: got %0d want 3", db_estado); end
        repeat (5) ciclo(4'b0000);
        n_checks++; if (db_estado !== 3'd3) begin n_erros++; $display("FAIL slide_wait: got %0d want 3", db_estado); end
        repeat (15) ciclo(4'b0000);
        n_checks++; if (db_estado !== 3'd0 || ocupado !== 1'b0) begin n_erros++; $display("FAIL slide_idle: got estado=%0d ocupado=%b want 0 0", db_estado, ocupado); end
    endtask

    task automatic test_aleatorio;
        int th, exp_n;
        logic [3:0] code;
        logic hab;
        for (int e = 0; e < 24; e++) begin
            code = 4'($urandom_range(1, 15));
            hab = ($urandom_range(0, 3) != 0);
            habilita = hab; n_strobe = 0; exp_n = 0;
            pressiona(code, $urandom_range(0, 3), $urandom_range(12, 25), th);
            if ($countones(code) > 1) m_erro = 1'b1;
            else if (hab) begin m_botoes = code; m_erro = 1'b0; exp_n = 1; end
            n_checks++; if (n_strobe !== exp_n) begin n_erros++; $display("FAIL rand_strobes[%0d] code=%b hab=%b: got %0d want %0d", e, code, hab, n_strobe, exp_n); end
            if (exp_n == 1) begin
                n_checks++; if (t_strobe - th < S + C - 1 || t_strobe - th > S + C + 1) begin n_erros++; $display("FAIL rand_latency[%0d]: got %0d want %0d+-1", e, t_strobe - th, S + C); end
            end
            n_checks++; if (ocupado !== 1'b1) begin n_erros++; $display("FAIL rand_ocupado[%0d]: got %b want 1", e, ocupado); end
            solta(code, $urandom_range(0, 3), $urandom_range(14, 20));
            n_checks++; if (botoes !== m_botoes || erro_multiplo !== m_erro) begin n_erros++; $display("FAIL rand_state[%0d]: got botoes=%b erro=%b want %b %b", e, botoes, erro_multiplo, m_botoes, m_erro); end
            n_checks++; if (ocupado !== 1'b0 || n_strobe !== exp_n) begin n_erros++; $display("FAIL rand_release[%0d]: got ocupado=%b strobes=%0d want 0 %0d", e, ocupado, n_strobe, exp_n); end
        end
        habilita = 1'b1;
    endtask

`ifdef BOTOES_CONTADOR_EN
    task automatic test_contador;
        int th;
        logic [3:0] code;
        reset = 1'b0; ciclo(4'b0000); reset = 1'b1;
        for (int i = 0; i < 257; i++) begin
            code = 4'(1 << (i % 4));
            pressiona(code, 0, 12, th);
            solta(code, 0, 12);
        end
        n_checks++; if (db_num_jogadas !== 8'(257 % 256)) begin n_erros++; $display("FAIL cont_wrap: got %0d want %0d", db_num_jogadas, 257 % 256); end
        reset = 1'b0; ciclo(4'b0000);
        n_checks++; if (db_num_jogadas !== 8'd0 || botoes !== 4'b0000) begin n_erros++; $display("FAIL cont_reset: got cont=%0d botoes=%b want 0 0000", db_num_jogadas, botoes); end
        reset = 1'b1;
    endtask
`endif

    initial begin
        botoes_brutos = 4'b0000;
        test_reset();
        test_bounce();
        test_multiplo();
        test_habilita();
        test_slide();
        test_aleatorio();
`ifdef BOTOES_CONTADOR_EN
        test_contador();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_erros);
        $finish;
    end

endmodule
